// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch bank write controller.
// State encoding and width helpers used by the FSM and the arbiter.
package latch_ctrl_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] SETUP_ENC = 2'd1;
    localparam logic [1:0] GATE_ENC  = 2'd2;
    localparam logic [1:0] HOLD_ENC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        SETUP = SETUP_ENC,
        GATE  = GATE_ENC,
        HOLD  = HOLD_ENC
    } state_t;

    // Never returns 0 so single-entry fields still get one bit.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int wrap(input int a, input int n);
        return (a >= n) ? a - n : a;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches from ptr upward, wrapping modulo N.
import latch_ctrl_pkg::*;

module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] winner
);

    logic [ID_W-1:0] idx;

    // Scan from the far end so the nearest requester to ptr wins last.
    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ID_W'(wrap(int'(ptr) + i, N));
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of transparent gated D latches.
// Data settles a full cycle before the gate opens and after it closes.
import latch_ctrl_pkg::*;

module latch_bank_write_ctrl #(
    parameter int N_REQ       = 4,
    parameter int N_WORDS     = 8,
    parameter int W           = 8,
    parameter int GATE_CYCLES = 2,
    localparam int ADDR_W     = clog2(N_WORDS),
    localparam int ID_W       = clog2(N_REQ)
) (
    input  logic                    c,
    input  logic                    rn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*W-1:0]      wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [W-1:0]            lat_d,
    output logic [N_WORDS-1:0]      lat_g,
    output logic                    busy,
    output logic [ID_W-1:0]         cur_id
);

    state_t            state;
    logic [3:0]        cnt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic              pick_valid;
    logic [ADDR_W-1:0] cap_addr;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (win)
    );

    // lat_d doubles as the data capture register.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            cur_id   <= '0;
            cap_addr <= '0;
            lat_d    <= '0;
            lat_g    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_id   <= win;
                        cap_addr <= addr[win*ADDR_W +: ADDR_W];
                        lat_d    <= wdata[win*W +: W];
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    lat_g[cap_addr] <= 1'b1;
                    cnt             <= 4'(GATE_CYCLES - 1);
                    state           <= GATE;
                end
                GATE: begin
                    if (cnt == 4'd0) begin
                        lat_g       <= '0;
                        ack[cur_id] <= 1'b1;
                        ptr         <= (cur_id == ID_W'(N_REQ - 1)) ?
                                       '0 : cur_id + 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/latch_bank_write_ctrl.md
# latch_bank_write_ctrl

Sequences writes into a bank of gated D latches (NAND-built, level-sensitive, ~30 ns gate-to-output) shared by several requesters. It arbitrates requesters round-robin, captures the winner's address and data, and drives the shared latch data bus and one-hot gate enables. The gate is opened only while data is already stable and is closed before data changes, so the transparent latches never see a data edge while open. It sits between requester logic and the latch bank; the bank itself is untouched.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_WORDS, 8, number of latch words in the bank (power of two)
- W, 8, word width (latches per word)
- GATE_CYCLES, 2, clock cycles the gate is held open (1..15)

Ports:
- c  in  1  clock, rising edge
- rn  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester write request, level
- addr  in  N_REQ*log2(N_WORDS)  per-requester word address, requester i at slice i
- wdata  in  N_REQ*W  per-requester write data, requester i at slice i
- ack  out  N_REQ  one-cycle completion pulse to the granted requester
- lat_d  out  W  shared data bus to all latch D inputs
- lat_g  out  N_WORDS  one-hot gate enables, bit k gates word k
- busy  out  1  high in any state other than IDLE
- cur_id  out  log2(N_REQ)  index of the current or last grantee

## Operation
- States: IDLE, SETUP, GATE, HOLD.
- IDLE: if any req is high, pick the winner by round-robin from pointer ptr (ptr first, then ptr+1, ... modulo N_REQ). Capture addr/wdata slices into internal registers, set cur_id, go to SETUP. Otherwise stay in IDLE.
- SETUP, 1 cycle: lat_d drives the captured data. lat_g is all zero. Go to GATE.
- GATE, GATE_CYCLES cycles, tracked by a down-counter: lat_g[captured addr] = 1 and all other bits are 0. lat_d stays stable. When the count expires, go to HOLD.
- HOLD, 1 cycle: lat_g is all zero and lat_d is still held. ack[cur_id] = 1. ptr becomes (cur_id+1) mod N_REQ. Go to IDLE.
- lat_d holds its last value in IDLE. It changes only on the IDLE->SETUP transition.
- The requester may change addr/wdata after the grant edge, because the values are captured. req must drop in the cycle after ack. If req is still high at the next IDLE evaluation, it counts as a new request.
- A req that drops during SETUP/GATE/HOLD is ignored and the transfer completes.
- At most one lat_g bit is high at any time. lat_g is never high in SETUP, HOLD or IDLE.
- Reset (rn low, asynchronous, any state including mid-GATE):
  - state = IDLE, lat_g = 0, ack = 0, busy = 0, ptr = 0, cur_id = 0, lat_d = 0, counter = 0.
  - Latch bank contents are not touched by the controller.
- lat_g, lat_d, ack, busy and cur_id are all registered outputs (no combinational path from req).

## Timing
- req is sampled high at edge k (IDLE). SETUP is visible after k, GATE for edges k+1..k+GATE_CYCLES, HOLD after k+GATE_CYCLES+1, and IDLE again after k+GATE_CYCLES+2.
- Transfer occupancy is GATE_CYCLES+2 cycles plus 1 IDLE evaluation cycle. Back-to-back throughput is one write per GATE_CYCLES+3 cycles.
- Data setup to gate-open is 1 full cycle and hold after gate-close is 1 full cycle. Both must exceed the latch path delay (≥30 ns), so clock period ≥ 30 ns.
- Reset release: the first arbitration occurs at the first rising edge with rn high.

## Structure
- Shared package `latch_ctrl_pkg` holds:
  - state encoding localparams (IDLE=0, SETUP=1, GATE=2, HOLD=3)
  - a clog2 function for the ADDR_W/ID_W derivation
- One sub-module, `rr_pick`: combinational round-robin selector with inputs req and ptr, outputs valid and winner index.
- The FSM, counter, capture registers and output registers live in `latch_bank_write_ctrl`.

## Test plan
- Single write (defaults): req[2]=1, addr2=5, wdata2=0xA5. Required response:
  - lat_d=0xA5 one cycle before lat_g=0x20.
  - lat_g=0x20 for exactly 2 cycles, then 0.
  - ack[2] pulses in the following cycle and cur_id=2.
  - The latch model word 5 reads 0xA5.
- Contention: req=4'b1111 held, with each requester releasing after its ack. Grants must go in order 0,1,2,3. Then re-raise req[0] and req[3] with ptr=0, and requester 0 wins.
- Fairness: req[1] and req[3] held continuously. Grants must alternate 1,3,1,3 and neither is starved over 8 transfers.
- Mid-transfer reset: rn pulses low during the 2nd GATE cycle. Required response:
  - lat_g=0 immediately (asynchronous), no ack, busy=0, ptr=0.
  - After release with req[3]=1, requester 3 is granted normally.
- Data change after grant: wdata0 changes from 0x3C to 0xFF during SETUP. lat_d stays 0x3C through HOLD and word addr0 stores 0x3C.
- GATE_CYCLES=1, N_REQ=2 build: back-to-back writes complete every 4 cycles, and lat_g is never high in two consecutive transfers without an intervening all-zero cycle.
